// File: rtl/perf_counter_bank.sv
// Bank of per-channel event counters with overflow flags, snapshot shadow,
// and a registered read port that can auto-scan channels for the display.
module perf_counter_bank #(
  parameter int NumCh    = 8,
  parameter int CntBit   = 32,
  parameter int SelBit   = 3,
  parameter int Saturate = 0,
  parameter int DwellCnt = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NumCh-1:0]  evt,
  input  logic              clr,
  input  logic              snap,
  input  logic              rd_shadow,
  input  logic [SelBit-1:0] sel,
  input  logic              scan_en,
  output logic [CntBit-1:0] rd_data,
  output logic [SelBit-1:0] rd_idx,
  output logic [NumCh-1:0]  ovf
);

  localparam int DwBit = (DwellCnt > 1) ? $clog2(DwellCnt) : 1;

  typedef enum logic {
    MANUAL,
    SCAN
  } state_t;

  state_t            state;
  logic [CntBit-1:0] cnt    [NumCh];
  logic [CntBit-1:0] shadow [NumCh];
  logic [SelBit-1:0] scan_idx;
  logic [DwBit-1:0]  dwell;
  logic [SelBit-1:0] k;
  logic [CntBit-1:0] rd_mux;

  always_comb begin
    k = (state == SCAN) ? scan_idx : sel;
  end

  // Indices past the last channel fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (int'(k) == i)
        rd_mux = rd_shadow ? shadow[i] : cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumCh; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
      ovf <= '0;
    end else begin
      if (snap) begin
        for (int i = 0; i < NumCh; i++)
          shadow[i] <= cnt[i];
      end
      for (int i = 0; i < NumCh; i++) begin
        if (clr) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (en && evt[i]) begin
          if (&cnt[i]) begin
            ovf[i] <= 1'b1;
            if (Saturate == 0)
              cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MANUAL;
      scan_idx <= '0;
      dwell    <= '0;
      rd_data  <= '0;
      rd_idx   <= '0;
    end else begin
      rd_data <= rd_mux;
      rd_idx  <= k;
      unique case (state)
        MANUAL: begin
          if (scan_en) begin
            state    <= SCAN;
            scan_idx <= '0;
            dwell    <= '0;
          end
        end
        SCAN: begin
          if (!scan_en) begin
            state <= MANUAL;
          end else if (dwell == DwBit'(DwellCnt - 1)) begin
            dwell <= '0;
            if (scan_idx == SelBit'(NumCh - 1))
              scan_idx <= '0;
            else
              scan_idx <= scan_idx + 1'b1;
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        default: state <= MANUAL;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: two configurations driven in lockstep and
// compared every cycle against an arithmetic reference model.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       rst, en, clr, snap, rd_shadow, scan_en;
  logic [7:0] evt;
  logic [2:0] sel;
  logic [7:0] rd0, rd1;
  logic [2:0] idx0, idx1;
  logic [7:0] ovf0;
  logic [5:0] ovf1;

  int ntest = 0;
  int nfail = 0;

  perf_counter_bank #(
    .NumCh(8), .CntBit(8), .SelBit(3), .Saturate(0), .DwellCnt(4)
  ) u0 (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .clr(clr), .snap(snap),
    .rd_shadow(rd_shadow), .sel(sel), .scan_en(scan_en),
    .rd_data(rd0), .rd_idx(idx0), .ovf(ovf0)
  );

  perf_counter_bank #(
    .NumCh(6), .CntBit(8), .SelBit(3), .Saturate(1), .DwellCnt(3)
  ) u1 (
    .clk(clk), .rst(rst), .en(en), .evt(evt[5:0]), .clr(clr), .snap(snap),
    .rd_shadow(rd_shadow), .sel(sel), .scan_en(scan_en),
    .rd_data(rd1), .rd_idx(idx1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  int unsigned mc [2][8];
  int unsigned ms [2][8];
  bit          mo [2][8];
  int unsigned mrd [2];
  int unsigned midx [2];
  bit          mscan [2];
  int          mt [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scan position is just elapsed scan cycles divided by the dwell time.
  task automatic model_edge();
    int n, dw, k;
    bit sat;
    for (int m = 0; m < 2; m++) begin
      n   = (m == 0) ? 8 : 6;
      dw  = (m == 0) ? 4 : 3;
      sat = (m == 1);
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          mc[m][i] = 0;
          ms[m][i] = 0;
          mo[m][i] = 0;
        end
        mrd[m] = 0;
        midx[m] = 0;
        mscan[m] = 0;
        mt[m] = 0;
      end else begin
        k = mscan[m] ? (mt[m] / dw) % n : int'(sel);
        mrd[m] = (k < n) ? (rd_shadow ? ms[m][k] : mc[m][k]) : 0;
        midx[m] = k;
        if (snap)
          for (int i = 0; i < n; i++) ms[m][i] = mc[m][i];
        for (int i = 0; i < n; i++) begin
          if (clr) begin
            mc[m][i] = 0;
            mo[m][i] = 0;
          end else if (en && evt[i]) begin
            if (mc[m][i] == 255) begin
              mo[m][i] = 1;
              if (!sat) mc[m][i] = 0;
            end else begin
              mc[m][i] = mc[m][i] + 1;
            end
          end
        end
        if (mscan[m]) begin
          if (!scan_en) mscan[m] = 0;
          else mt[m] = mt[m] + 1;
        end else if (scan_en) begin
          mscan[m] = 1;
          mt[m] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] e0;
    logic [5:0] e1;
    for (int i = 0; i < 8; i++) e0[i] = mo[0][i];
    for (int i = 0; i < 6; i++) e1[i] = mo[1][i];
    chk("rd0", rd0, mrd[0]);
    chk("idx0", idx0, midx[0]);
    chk("ovf0", ovf0, e0);
    chk("rd1", rd1, mrd[1]);
    chk("idx1", idx1, midx[1]);
    chk("ovf1", ovf1, e1);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1; en = 0; clr = 0; snap = 0; rd_shadow = 0;
    scan_en = 0; evt = '0; sel = '0;
    tick();
    tick();
    chk("rst_rd0", rd0, 0);
    chk("rst_ovf0", ovf0, 0);
    rst = 0;

    en = 1; evt = 8'h01;
    repeat (10) tick();
    evt = 8'h00;
    tick();
    chk("cnt0_10", rd0, 10);
    for (int i = 1; i < 8; i++) begin
      sel = 3'(i);
      tick();
      chk("other_zero", rd0, 0);
      chk("other_idx", idx0, i);
    end

    sel = 0;
    clr = 1;
    tick();
    clr = 0;
    evt = 8'h01;
    for (int c = 1; c <= 10; c++) begin
      en = !(c >= 4 && c <= 6);
      tick();
    end
    en = 1; evt = 8'h00;
    tick();
    chk("gated_7", rd0, 7);
    chk("gated_ovf", ovf0, 0);

    clr = 1;
    tick();
    clr = 0;
    sel = 2; evt = 8'h04;
    repeat (257) tick();
    evt = 8'h00;
    tick();
    chk("wrap_cnt", rd0, 1);
    chk("wrap_ovf", ovf0[2], 1);
    chk("sat_cnt", rd1, 255);
    chk("sat_ovf", ovf1[2], 1);

    clr = 1;
    tick();
    clr = 0;
    evt = 8'h02;
    repeat (5) tick();
    snap = 1; clr = 1;
    tick();
    snap = 0; clr = 0; evt = 8'h00;
    sel = 1; rd_shadow = 1;
    tick();
    chk("snap_sh", rd0, 5);
    rd_shadow = 0;
    tick();
    chk("snap_live", rd0, 0);
    chk("snap_ovf", ovf0, 0);

    sel = 5; scan_en = 1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (j == 1) chk("scan_entry", idx0, 5);
      else chk("scan_seq", idx0, ((j - 2) / 4) % 8);
    end
    scan_en = 0; sel = 3;
    tick();
    tick();
    chk("scan_exit0", idx0, 3);
    chk("scan_exit1", idx1, 3);

    sel = 7;
    tick();
    chk("oob_rd", rd1, 0);
    chk("oob_idx", idx1, 7);

    scan_en = 1; evt = 8'hff;
    repeat (6) tick();
    rst = 1;
    tick();
    chk("rst_scan_rd", rd0, 0);
    chk("rst_scan_idx", idx0, 0);
    rst = 0; sel = 2;
    tick();
    chk("rst_manual", idx0, 2);
    scan_en = 0;

    for (int j = 0; j < 400; j++) begin
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 3) != 0);
      evt = 8'($urandom);
      snap = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 31) == 0);
      rd_shadow = 1'($urandom);
      sel = 3'($urandom);
      if ($urandom_range(0, 15) == 0) scan_en = ~scan_en;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised successor to the per-event cycle/jump/branch/nop/predict counters in the core top level.
- Replaces N separately instantiated 32-bit counters with one bank of NumCh event counters.
- Adds wrap or saturate modes, sticky overflow flags, an atomic snapshot shadow bank, global clear, and a registered read port.
- The read port has a manual select mode and an auto-scan mode that cycles channels onto the 7-segment display path.
- Sits between the core's event strobes and the display data mux; clocked by the selected core clock.

Parameters:
- NumCh, 8, number of event channels (1..32).
- CntBit, 32, width of each counter (8..64).
- SelBit, 3, width of channel select; must satisfy 2^SelBit >= NumCh.
- Saturate, 0, 0 = counters wrap to 0, 1 = counters hold at all-ones.
- DwellCnt, 4, core cycles each channel is shown in auto-scan (>= 1).

Ports:
- clk, input, 1, core clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, core run enable; counting is gated by this.
- evt, input, NumCh, per-channel event strobes, sampled each cycle.
- clr, input, 1, synchronous clear of live counters and ovf flags.
- snap, input, 1, copy all live counters into the shadow bank.
- rd_shadow, input, 1, 0 = read live counters, 1 = read shadow counters.
- sel, input, SelBit, manual read channel.
- scan_en, input, 1, auto-scan mode enable.
- rd_data, output, CntBit, registered read data.
- rd_idx, output, SelBit, channel index that rd_data belongs to.
- ovf, output, NumCh, sticky per-channel overflow flags.

Behaviour:
- Reset: while rst=1 at an edge, the following are cleared to 0: all live counters, the shadow bank, ovf, rd_data, rd_idx, the scan index and the dwell counter. The FSM goes to MANUAL. rst overrides every other input.
- Increment: cnt[i] increments by exactly 1 when en=1 and evt[i]=1. Multiple channels may increment in the same cycle, each independently.
- Overflow, Saturate=0: all-ones wraps to 0 and ovf[i] is set.
- Overflow, Saturate=1: the counter holds at all-ones and ovf[i] is set on the first attempted increment past max.
- ovf[i] stays set until clr or rst.
- Clear: clr=1 zeroes all live counters and ovf, with priority over increments in the same cycle. clr does not affect the shadow bank, rd_data or the FSM.
- Snapshot: snap=1 writes the live values as they were before this edge into shadow[i] for all i, atomically.
- snap together with an increment: the shadow receives the pre-increment value; the live counter still increments.
- snap together with clr: the shadow receives the pre-clear values; the live counters are cleared.
- snap is independent of en.
- Read path: 1-cycle latency. At each edge, rd_data <= (rd_shadow ? shadow[k] : cnt[k]) and rd_idx <= k, where k is the effective index.
- Values read are pre-edge values: a live read in the same cycle as an increment returns the old count.
- If k >= NumCh, rd_data <= 0.
- FSM, MANUAL state: k = sel.
  - scan_en=1 moves to SCAN at the next edge, with scan index = 0 and dwell = 0.
- FSM, SCAN state: k = scan index; sel is ignored.
  - The dwell counter increments every cycle, regardless of en.
  - When dwell = DwellCnt-1, dwell returns to 0 and the scan index advances, wrapping from NumCh-1 to 0.
  - scan_en=0 moves to MANUAL at the next edge.
  - On a later re-entry to SCAN, the index restarts at 0.
- Reset mid-scan: the FSM returns to MANUAL immediately at that edge.
- Widths: all counter arithmetic is modulo 2^CntBit. There is no sign extension; all values are unsigned.

Test Plan:
- Reset release, then hold evt[0]=1 and en=1 for 10 cycles with sel=0 and rd_shadow=0 -> rd_data reads 10 one cycle after the last event; all other channels read 0.
- Same stimulus with en=0 for cycles 4..6 -> cnt[0]=7; ovf=0.
- CntBit=8, Saturate=0: 257 events on channel 2 -> cnt[2]=1 and ovf[2]=1. Saturate=1 variant -> cnt[2]=255 and ovf[2]=1.
- cnt[1]=5 and evt[1]=1 with snap=1 and clr=1 in the same cycle -> shadow[1]=5 and live cnt[1]=0; ovf cleared; a shadow read of channel 1 returns 5.
- DwellCnt=4, NumCh=8, scan_en=1 for 40 cycles -> rd_idx runs 0,0,0,0,1,1,1,1,...,7 then wraps to 0, offset by 1-cycle latency. Dropping scan_en -> rd_idx follows sel on the next cycle.
- sel=7 with NumCh=6 -> rd_data=0. rst=1 during SCAN -> rd_data=0, rd_idx=0, and the FSM returns to MANUAL the next cycle.
